// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the single-clock FIFO and anything that talks to it:
// default data width, depth and almost-full/almost-empty thresholds, the
// derived pointer/count widths, and the registered status bundle.
package fifo_pkg;

  localparam int DATA_W       = 8;
  localparam int DEPTH        = 16;
  localparam int ALM_FULL_TH  = 2;
  localparam int ALM_EMPTY_TH = 2;
  localparam int ADDR_W       = $clog2(DEPTH);
  localparam int CNT_W        = ADDR_W + 1;

  typedef struct packed {
    logic full;
    logic alm_full;
    logic empty;
    logic alm_empty;
  } fifo_status_t;

  // Status flags as a pure function of an occupancy value. The FIFO feeds it
  // the next-state count so the registered flags line up with o_count.
  function automatic fifo_status_t fifo_status(input int cnt, input int depth,
                                               input int afth, input int aeth);
    fifo_status_t s;
    s.full      = (cnt == depth);
    s.alm_full  = ((depth - cnt) <= afth);
    s.empty     = (cnt == 0);
    s.alm_empty = (cnt <= aeth);
    return s;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// DEPTH x DW simple dual-port storage: synchronous write, registered read.
// No reset on the array or the read register.
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_re     : read enable; o_rdata updates only when set
//   i_raddr  : read address
//   o_rdata  : registered read data (holds between reads)
module fifo_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // A read and a write to the same address in one cycle returns the old
  // word; the FIFO relies on this when it is full and both sides fire.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/sync_fifo_core.sv
// sync_fifo_core
// Single-clock FIFO with registered status flags, occupancy count, flush and
// sticky overflow/underflow flags.
//   clk          : clock, all state on rising edge
//   rstn         : asynchronous active-low reset
//   i_wren       : write request, i_wrdata sampled with it
//   i_rden       : read request, o_rddata valid one cycle after acceptance
//   i_flush      : synchronous flush, priority over reads and writes
//   o_rddata     : registered read data, holds on idle/rejected reads
//   o_full/o_alm_full/o_empty/o_alm_empty : registered status
//   o_count      : occupancy
//   o_overflow   : sticky, a write was dropped
//   o_underflow  : sticky, a read was rejected
module sync_fifo_core
  import fifo_pkg::*;
#(
  parameter int DATA_W       = fifo_pkg::DATA_W,
  parameter int DEPTH        = fifo_pkg::DEPTH,
  parameter int ALM_FULL_TH  = fifo_pkg::ALM_FULL_TH,
  parameter int ALM_EMPTY_TH = fifo_pkg::ALM_EMPTY_TH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_wren,
  input  logic [DATA_W-1:0]        i_wrdata,
  input  logic                     i_rden,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_rddata,
  output logic                     o_full,
  output logic                     o_alm_full,
  output logic                     o_empty,
  output logic                     o_alm_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count;
  fifo_status_t       r_stat;
  logic               r_ovf, r_udf;
  // Clear until the first accepted read after reset; lets o_rddata read as
  // zero out of reset even though the RAM read register is not reset.
  logic               r_rd_seen;

  logic               w_full, w_empty;
  logic               w_wr_ok, w_rd_ok;
  logic               w_ram_we, w_ram_re;
  logic [CW-1:0]      w_count_nxt;
  fifo_status_t       w_stat_nxt;
  logic [DATA_W-1:0]  w_ram_q;

  always_comb begin
    w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    w_empty     = (r_wr_ptr == r_rd_ptr);
    w_rd_ok     = i_rden && !w_empty;
    // A full FIFO still takes a write when a read frees the head slot.
    w_wr_ok     = i_wren && (!w_full || w_rd_ok);
    w_ram_we    = w_wr_ok && !i_flush;
    w_ram_re    = w_rd_ok && !i_flush;
    w_count_nxt = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
    w_stat_nxt  = fifo_status(int'(w_count_nxt), DEPTH, ALM_FULL_TH, ALM_EMPTY_TH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_stat    <= fifo_status(0, DEPTH, ALM_FULL_TH, ALM_EMPTY_TH);
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_rd_seen <= 1'b0;
    end else if (i_flush) begin
      // r_rd_seen is left alone so o_rddata keeps its last value.
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_stat    <= fifo_status(0, DEPTH, ALM_FULL_TH, ALM_EMPTY_TH);
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_seen <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_stat  <= w_stat_nxt;
      if (i_wren && !w_wr_ok) r_ovf <= 1'b1;
      if (i_rden && w_empty)  r_udf <= 1'b1;
    end
  end

  fifo_ram #(
    .DW    (DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (i_wrdata),
    .i_re    (w_ram_re),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_q)
  );

  assign o_rddata    = r_rd_seen ? w_ram_q : '0;
  assign o_full      = r_stat.full;
  assign o_alm_full  = r_stat.alm_full;
  assign o_empty     = r_stat.empty;
  assign o_alm_empty = r_stat.alm_empty;
  assign o_count     = r_count;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_udf;

endmodule

// File: tb/tb_sync_fifo_core.sv
module tb_sync_fifo_core;

  localparam int DEPTH = 16;
  localparam int AF_TH = 2;
  localparam int AE_TH = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_wren = 1'b0, i_rden = 1'b0, i_flush = 1'b0;
  logic [7:0] i_wrdata = '0;
  logic [7:0] o_rddata;
  logic       o_full, o_alm_full, o_empty, o_alm_empty, o_overflow, o_underflow;
  logic [4:0] o_count;

  int n_chk = 0;
  int n_err = 0;

  sync_fifo_core dut (
    .clk(clk), .rstn(rstn), .i_wren(i_wren), .i_wrdata(i_wrdata),
    .i_rden(i_rden), .i_flush(i_flush), .o_rddata(o_rddata),
    .o_full(o_full), .o_alm_full(o_alm_full), .o_empty(o_empty),
    .o_alm_empty(o_alm_empty), .o_count(o_count),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of words plus the last word read and the
  // two sticky flags.
  logic [7:0] q[$];
  logic [7:0] m_rd  = '0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (i_flush) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      int  n;
      bit  rd_ok, wr_ok;
      n     = q.size();
      rd_ok = i_rden && (n > 0);
      wr_ok = i_wren && ((n < DEPTH) || rd_ok);
      if (rd_ok) m_rd = q.pop_front();
      if (wr_ok) q.push_back(i_wrdata);
      if (i_wren && !wr_ok) m_ovf = 1'b1;
      if (i_rden && n == 0) m_udf = 1'b1;
    end
  end

  // Compare process: every falling edge, DUT against the model.
  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("m_count",     32'(o_count),     32'(n));
    chk("m_rddata",    32'(o_rddata),    32'(m_rd));
    chk("m_full",      32'(o_full),      32'(n == DEPTH));
    chk("m_alm_full",  32'(o_alm_full),  32'((DEPTH - n) <= AF_TH));
    chk("m_empty",     32'(o_empty),     32'(n == 0));
    chk("m_alm_empty", 32'(o_alm_empty), 32'(n <= AE_TH));
    chk("m_overflow",  32'(o_overflow),  32'(m_ovf));
    chk("m_underflow", 32'(o_underflow), 32'(m_udf));
  end

  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
    i_wren = wr; i_wrdata = d; i_rden = rd; i_flush = fl;
    @(negedge clk);
  endtask

  initial begin
    int w;
    // 1. reset, release, idle
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cyc(0, 8'h00, 0, 0);
    chk("t1_count", 32'(o_count), 0);
    chk("t1_empty", 32'(o_empty), 1);
    chk("t1_alm_empty", 32'(o_alm_empty), 1);
    chk("t1_rddata", 32'(o_rddata), 0);
    chk("t1_errs", {o_overflow, o_underflow}, 0);

    // 2. fill to full, overflow, drain in order
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 8'(k), 0, 0);
      chk("t2_count", 32'(o_count), 32'(k));
      chk("t2_alm_empty", 32'(o_alm_empty), 32'(k <= 2));
      chk("t2_alm_full", 32'(o_alm_full), 32'(k >= 14));
      chk("t2_full", 32'(o_full), 32'(k == 16));
    end
    cyc(1, 8'hAA, 0, 0);
    chk("t2_ovf", 32'(o_overflow), 1);
    chk("t2_ovf_count", 32'(o_count), 16);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 8'h00, 1, 0);
      chk("t2_rd", 32'(o_rddata), 32'(k));
    end
    cyc(0, 8'h00, 0, 0);
    chk("t2_hold", 32'(o_rddata), 32'h10);
    chk("t2_empty", 32'(o_empty), 1);

    // 3. full with simultaneous read/write across wrap
    cyc(0, 8'h00, 0, 1);
    chk("t3_ovf_clr", 32'(o_overflow), 0);
    w = 0;
    for (int k = 0; k < 16; k++) begin cyc(1, 8'(8'h30 + w), 0, 0); w++; end
    chk("t3_full", 32'(o_full), 1);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 8'(8'h30 + w), 1, 0); w++;
      chk("t3_count", 32'(o_count), 16);
      chk("t3_rd", 32'(o_rddata), 32'(8'h30 + k));
      chk("t3_ovf", 32'(o_overflow), 0);
    end
    for (int k = 20; k < 36; k++) begin
      cyc(0, 8'h00, 1, 0);
      chk("t3_drain", 32'(o_rddata), 32'(8'h30 + k));
    end
    chk("t3_empty", 32'(o_empty), 1);

    // 4. empty with write+read together
    cyc(1, 8'h5A, 1, 0);
    chk("t4_count", 32'(o_count), 1);
    chk("t4_udf", 32'(o_underflow), 1);
    chk("t4_rd_hold", 32'(o_rddata), 32'h53);
    cyc(0, 8'h00, 1, 0);
    chk("t4_rd", 32'(o_rddata), 32'h5A);

    // 5. flush with a concurrent write
    for (int k = 0; k < 5; k++) cyc(1, 8'(8'h60 + k), 0, 0);
    chk("t5_count", 32'(o_count), 5);
    cyc(1, 8'hEE, 0, 1);
    chk("t5_count0", 32'(o_count), 0);
    chk("t5_empty", 32'(o_empty), 1);
    chk("t5_errs", {o_overflow, o_underflow}, 0);
    chk("t5_rd_hold", 32'(o_rddata), 32'h5A);
    cyc(0, 8'h00, 0, 0);
    chk("t5_dropped", 32'(o_count), 0);

    // 6. asynchronous reset mid-operation
    for (int k = 0; k < 9; k++) cyc(1, 8'(8'h70 + k), 0, 0);
    chk("t6_count9", 32'(o_count), 9);
    #2 rstn = 1'b0;
    #1;
    chk("t6_count", 32'(o_count), 0);
    chk("t6_flags", {o_full, o_alm_full, o_empty, o_alm_empty}, 32'b0011);
    chk("t6_rddata", 32'(o_rddata), 0);
    chk("t6_errs", {o_overflow, o_underflow}, 0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1, 8'h99, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("t6_rd", 32'(o_rddata), 32'h99);

    // Randomized traffic: write-heavy, read-heavy, then balanced phases.
    for (int k = 0; k < 1800; k++) begin
      int wp, rp;
      wp = (k < 600) ? 75 : (k < 1200) ? 30 : 50;
      rp = (k < 600) ? 35 : (k < 1200) ? 75 : 50;
      cyc(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0, 8'($urandom),
          ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
          ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    cyc(0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
Single-clock FIFO that responds to the write/read traffic issued by the bench driver over the shared FIFO interface. It accepts i_wren/i_wrdata, returns o_rddata on i_rden, and reports full, almost-full, empty and almost-empty status that the monitor samples. It also provides an occupancy count, a synchronous flush and sticky overflow/underflow error flags for scoreboard checking.

Parameters:
DATA_W, 8, data word width; sourced from the shared package so it matches the interface.
DEPTH, 16, number of entries; must be a power of two and at least 4.
ALM_FULL_TH, 2, o_alm_full is asserted when free slots are less than or equal to this value.
ALM_EMPTY_TH, 2, o_alm_empty is asserted when count is less than or equal to this value.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rstn  input  1  asynchronous, active-low reset.
i_wren  input  1  write request.
i_wrdata  input  DATA_W  write data, sampled with i_wren.
i_rden  input  1  read request.
i_flush  input  1  synchronous flush; drops all contents.
o_rddata  output  DATA_W  registered read data.
o_full  output  1  count == DEPTH.
o_alm_full  output  1  DEPTH - count <= ALM_FULL_TH.
o_empty  output  1  count == 0.
o_alm_empty  output  1  count <= ALM_EMPTY_TH.
o_count  output  $clog2(DEPTH)+1  current occupancy.
o_overflow  output  1  sticky flag: a write was dropped.
o_underflow  output  1  sticky flag: a read was rejected.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rstn. While rstn=0, all of the following hold:
  - pointers = 0, o_count = 0, o_rddata = 0
  - o_empty = 1, o_alm_empty = 1, o_full = 0, o_alm_full = 0
  - o_overflow = 0, o_underflow = 0
  - Memory contents are not reset.
- Pointers: write and read pointers are ADDR_W+1 bits wide (ADDR_W = $clog2(DEPTH)). The MSB is the wrap bit.
  - full = (addresses equal) and (wrap bits differ).
  - empty = pointers fully equal.
  - Pointers increment modulo 2*DEPTH.
- Accept rules, evaluated on the registered state before the edge:
  - wr_ok = i_wren and (not full, or rd_ok).
  - rd_ok = i_rden and not empty.
  - Full with both requests: both are accepted and count is unchanged.
  - Empty with both requests: the write is accepted, the read is rejected and o_underflow is set.
- Read latency is 1 cycle. If i_rden is accepted at edge N, o_rddata carries the head word after edge N. o_rddata holds its last value on idle cycles and on rejected reads.
- Write data is stored at edge N and is readable from edge N+1. There is no fall-through.
- Count and flags:
  - o_count = count + wr_ok - rd_ok, registered.
  - All four status flags are registered and derived from the next count, so they are consistent with o_count in the same cycle.
- Error flags:
  - i_wren while full and no accepted read: data is dropped and o_overflow is set.
  - i_rden while empty: o_underflow is set.
  - Both flags are sticky until reset or i_flush.
- Flush: i_flush=1 at an edge sets both pointers to 0, count to 0, the flags to their reset values, and clears both sticky errors. It has priority over i_wren and i_rden in the same cycle. o_rddata is unchanged.
- Reset mid-operation: everything listed under Reset returns to its reset value immediately. No partial transaction survives.

Decomposition:
- Shared package fifo_pkg holds DATA_W, DEPTH, the threshold defaults, the derived ADDR_W/CNT_W localparams and a status struct {full, alm_full, empty, alm_empty}. The interface and this block both import fifo_pkg.
- One sub-module is natural: fifo_ram. It is a DEPTH x DATA_W simple dual-port array with a synchronous write and a registered read, uses no reset, and is instantiated once.

Test Plan:
All scenarios use DEPTH=16, DATA_W=8, ALM_FULL_TH=2, ALM_EMPTY_TH=2.
1. Release reset, then idle -> o_empty=1, o_alm_empty=1, o_count=0, o_rddata=0x00, both error flags 0.
2. Write 0x01..0x10 on consecutive cycles -> o_alm_empty drops when o_count=3, o_alm_full rises at o_count=14, o_full=1 at 16. A 17th write of 0xAA sets o_overflow with o_count still 16. Reading all 16 words returns 0x01..0x10 in order, each one cycle after its i_rden, and the 0xAA word never appears.
3. Keep FIFO full and assert i_wren and i_rden together for 20 cycles -> o_count stays 16, o_overflow stays 0, and the read stream continues in order across pointer wrap-around.
4. Empty FIFO with i_wren=1 (0x5A) and i_rden=1 in the same cycle -> o_count=1, o_underflow=1, o_rddata unchanged. The next read returns 0x5A.
5. Fill 5 words, assert i_flush together with i_wren -> o_count=0, o_empty=1, o_underflow/o_overflow cleared, and the write is dropped.
6. Drop rstn asynchronously between clock edges with o_count=9 -> outputs go to reset values before the next clk edge. After release, the first write/read pair returns the newly written data.
